// File: rtl/demux3_buf.sv
// One-to-three stream router: each accepted word lands in a one-entry buffer
// for the decoded destination, with independent valid/ready drain per output.

module demux3_buf_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             out_ready,
  output logic             full,
  output logic [WIDTH-1:0] data
);
  // A load wins over a drain, so a ready consumer is refilled with no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      full <= 1'b0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      data <= data_in;
    end else if (full && out_ready) begin
      full <= 1'b0;
    end
  end
endmodule

module demux3_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       selector,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] data_out_0,
  output logic [WIDTH-1:0] data_out_1,
  output logic [WIDTH-1:0] data_out_2,
  output logic             out_valid_0,
  output logic             out_valid_1,
  output logic             out_valid_2,
  input  logic             out_ready_0,
  input  logic             out_ready_1,
  input  logic             out_ready_2,
  input  logic             err_clr,
  output logic             sel_error
);
  localparam int NUM_DEST = 3;

  logic [NUM_DEST-1:0]            full;
  logic [NUM_DEST-1:0]            oready;
  logic [NUM_DEST-1:0]            load;
  logic [NUM_DEST-1:0][WIDTH-1:0] data;
  logic [1:0]                     tgt;
  logic                           bad_sel;
  logic                           accept;

  assign oready = {out_ready_2, out_ready_1, out_ready_0};

  // Unused codes fall back to destination 0 and are flagged.
  always_comb begin
    tgt     = 2'd0;
    bad_sel = 1'b0;
    case (selector)
      3'b000:  tgt = 2'd0;
      3'b001:  tgt = 2'd1;
      3'b010:  tgt = 2'd2;
      default: bad_sel = 1'b1;
    endcase
  end

  assign in_ready = !full[tgt] || oready[tgt];
  assign accept   = in_valid && in_ready;

  for (genvar i = 0; i < NUM_DEST; i++) begin : g_dest
    assign load[i] = accept && (tgt == 2'(i));

    demux3_buf_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .reset     (reset),
      .load      (load[i]),
      .data_in   (data_in),
      .out_ready (oready[i]),
      .full      (full[i]),
      .data      (data[i])
    );
  end

  // Set has priority over clear.
  always_ff @(posedge clk) begin
    if (reset)                   sel_error <= 1'b0;
    else if (accept && bad_sel)  sel_error <= 1'b1;
    else if (err_clr)            sel_error <= 1'b0;
  end

  assign out_valid_0 = full[0];
  assign out_valid_1 = full[1];
  assign out_valid_2 = full[2];
  assign data_out_0  = data[0];
  assign data_out_1  = data[1];
  assign data_out_2  = data[2];
endmodule
